ras_recovery_ctrl: RTL
======================

Name: ras_recovery_ctrl

Overview:
Controller that sequences the speculative return_address_stack used by fetch.
- Normal operation: converts fetch-side call/ret hints into RAS push/pop commands.
- In parallel: maintains an architectural (commit-time) copy of the call stack.
- On a mispredict: flushes the speculative RAS, then replays the committed entries into it one per cycle, stalling fetch and commit until the stack is consistent.
- Sits between the fetch/predecode stage, the ROB commit port and the return_address_stack instance.

Parameters:
- DEPTH, 8: entries in both the speculative RAS and the committed copy; power of two, ≥2.
- XLEN, 32: return-address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fe_valid  in  1  fetch presents a predecoded control instruction
- fe_is_call  in  1  instruction is a call (link rd = x1/x5)
- fe_is_ret  in  1  instruction is a return (rs1 = x1/x5)
- fe_link_addr  in  XLEN  PC+4 of the instruction
- fe_ready  out  1  controller accepts the fetch op this cycle
- cm_valid  in  1  ROB commits a control instruction
- cm_is_call  in  1  committed instruction is a call
- cm_is_ret  in  1  committed instruction is a return
- cm_link_addr  in  XLEN  committed PC+4
- cm_ready  out  1  commit may proceed
- mispredict  in  1  backend redirect, single-cycle pulse
- recovering  out  1  high in FLUSH/REPLAY
- ras_flush  out  1  to RAS flush
- ras_push  out  1  to RAS push
- ras_push_addr  out  XLEN  to RAS push_addr
- ras_pop  out  1  to RAS pop

Behaviour:
- **FSM states:** IDLE, CORO (coroutine second half), FLUSH, REPLAY.
- **Reset:**
  - state=IDLE, committed count cnt=0, replay index ridx=0.
  - All outputs 0 while rst is high; fe_ready=1 and cm_ready=1 from the first cycle after reset.
- **IDLE, fetch side:**
  - fe_ready = !mispredict.
  - Accepted op (fe_valid & fe_ready):
    - call only → ras_push=1, ras_push_addr=fe_link_addr.
    - ret only → ras_pop=1.
    - call & ret (coroutine) → ras_pop=1 this cycle, fe_ready=0, go CORO.
- **CORO:** ras_push=1 with the link address latched in IDLE; fe_ready=1 so fetch retires the op; return to IDLE. Mispredict in CORO overrides: no push, go FLUSH.
- **ras_push and ras_pop:** never asserted in the same cycle.
- **Commit side (cm_ready = state is IDLE or CORO):**
  - Committed copy is an XLEN×DEPTH array plus cnt (0..DEPTH).
  - call → write entry[cnt] and increment, only if cnt<DEPTH (saturate and drop, matching RAS full behaviour).
  - ret → decrement if cnt>0.
  - call & ret → entry[cnt-1] overwritten if cnt>0, else entry[0] written and cnt=1.
  - A commit in the same cycle as mispredict is applied before recovery starts.
- **Mispredict (sampled at the clock edge in IDLE, CORO or REPLAY):** next state FLUSH. In the mispredict cycle, fe_ready=0 and no RAS command is issued.
- **FLUSH (1 cycle):**
  - ras_flush=1, cm_ready=0, fe_ready=0, ridx←0.
  - Next state REPLAY if cnt>0, else IDLE.
- **REPLAY:**
  - Per cycle: ras_push=1, ras_push_addr=entry[ridx], ridx++; cm_ready=0, fe_ready=0.
  - Return to IDLE after pushing ridx=cnt-1.
  - Recovery latency = 1+cnt cycles after the mispredict cycle.
- **Mispredict during REPLAY:** restart at FLUSH; partial replay is discarded.
- **Reset mid-recovery:** immediate return to IDLE; cnt cleared.
- **recovering:** 1 exactly in FLUSH and REPLAY.
- **Widths:**
  - cnt is $clog2(DEPTH)+1 bits.
  - ridx is $clog2(DEPTH) bits; it does not wrap because replay stops at cnt-1.

Decomposition:
- ras_pkg: state enum ras_ctl_state_t {IDLE, CORO, FLUSH, REPLAY}; typedef ras_op_t (push/pop/flush + addr struct).
- One sub-module: ras_commit_stack, the committed array plus cnt with commit-update logic and an indexed read port. The controller FSM and output muxing stay in ras_recovery_ctrl.
- The bench instantiates ras_recovery_ctrl together with return_address_stack.

Test Plan:
1. Three fetch calls (0x100, 0x200, 0x300), then one ret → pushes on cycles 1–3, pop on cycle 4; RAS top = 0x200.
2. Commit calls 0x100, 0x200; fetch speculatively pushes 0x900, 0xA00; mispredict pulse:
   - next cycle ras_flush=1;
   - then pushes 0x100, 0x200 on consecutive cycles;
   - recovering high exactly 3 cycles; fe_ready/cm_ready low throughout;
   - RAS top = 0x200.
3. Mispredict with cnt=0 → FLUSH only, back to IDLE after 1 cycle, RAS empty.
4. Fetch coroutine (call & ret, link 0x400) with RAS top 0x100:
   - cycle 1: pop, fe_ready=0;
   - cycle 2: push 0x400, fe_ready=1;
   - never push and pop together.
5. Commit 9 calls with DEPTH=8 → cnt saturates at 8; after mispredict, replay pushes exactly the first 8 addresses.
6. Mispredict again during the 2nd REPLAY cycle → FLUSH re-asserted next cycle, full replay restarts from entry[0]; rst mid-REPLAY → IDLE, cnt=0, no further pushes.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types for the return-address-stack recovery controller: FSM state
// encoding and the RAS command bundle.
package ras_pkg;

    typedef logic [1:0] ras_ctl_state_t;

    localparam ras_ctl_state_t ST_IDLE   = 2'd0;
    localparam ras_ctl_state_t ST_CORO   = 2'd1;
    localparam ras_ctl_state_t ST_FLUSH  = 2'd2;
    localparam ras_ctl_state_t ST_REPLAY = 2'd3;

    typedef struct packed {
        logic flush;
        logic push;
        logic pop;
    } ras_cmd_t;

    localparam ras_cmd_t RAS_CMD_NONE = '{flush: 1'b0, push: 1'b0, pop: 1'b0};

endpackage

// File: rtl/ras_commit_stack.sv
// Architectural (commit-time) copy of the call stack with an indexed read port
// used to replay entries into the speculative RAS after a mispredict.
module ras_commit_stack
    import ras_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cm_en,
    input  logic                       cm_is_call,
    input  logic                       cm_is_ret,
    input  logic [XLEN-1:0]            cm_link_addr,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [XLEN-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  mem_r [DEPTH];
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_m1_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;

    assign cnt_m1_s = cnt_r - CNT_ONE;

    // Commit update: calls saturate at DEPTH, a call+ret replaces the top entry.
    always_comb begin
        cnt_nxt_s = cnt_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = {IDX_W{1'b0}};
        if (cm_en && cm_is_call && cm_is_ret) begin
            wr_en_s = 1'b1;
            if (cnt_r != CNT_ZERO) begin
                wr_idx_s = cnt_m1_s[IDX_W-1:0];
            end else begin
                wr_idx_s  = {IDX_W{1'b0}};
                cnt_nxt_s = CNT_ONE;
            end
        end else if (cm_en && cm_is_call) begin
            if (cnt_r != CNT_FULL) begin
                wr_en_s   = 1'b1;
                wr_idx_s  = cnt_r[IDX_W-1:0];
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                wr_en_s   = 1'b0;
            end
        end else if (cm_en && cm_is_ret) begin
            if (cnt_r != CNT_ZERO) begin
                cnt_nxt_s = cnt_m1_s;
            end else begin
                cnt_nxt_s = CNT_ZERO;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Entry storage; contents beyond cnt are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= cm_link_addr;
        end
    end

    assign rd_data = mem_r[rd_idx];
    assign cnt     = cnt_r;

endmodule

// File: rtl/return_address_stack.sv
// Speculative return-address stack driven by the recovery controller;
// pushes beyond DEPTH are dropped and pops of an empty stack are ignored.
module return_address_stack #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [XLEN-1:0]         push_addr,
    input  logic                    pop,
    output logic [XLEN-1:0]         top,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  mem_r [DEPTH];
    logic [CNT_W-1:0] sp_r;
    logic [CNT_W-1:0] sp_m1_s;

    assign sp_m1_s = sp_r - CNT_ONE;

    // Stack pointer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sp_r <= CNT_ZERO;
        end else if (push && (sp_r != CNT_FULL)) begin
            sp_r <= sp_r + CNT_ONE;
        end else if (pop && (sp_r != CNT_ZERO)) begin
            sp_r <= sp_m1_s;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push && (sp_r != CNT_FULL)) begin
            mem_r[sp_r[IDX_W-1:0]] <= push_addr;
        end
    end

    assign top   = (sp_r != CNT_ZERO) ? mem_r[sp_m1_s[IDX_W-1:0]] : {XLEN{1'b0}};
    assign count = sp_r;

endmodule

// File: rtl/ras_recovery_ctrl.sv
// Sequences the speculative RAS: translates fetch call/ret hints into push/pop
// and, after a mispredict, flushes and replays the committed call stack.
module ras_recovery_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fe_valid,
    input  logic             fe_is_call,
    input  logic             fe_is_ret,
    input  logic [XLEN-1:0]  fe_link_addr,
    output logic             fe_ready,
    input  logic             cm_valid,
    input  logic             cm_is_call,
    input  logic             cm_is_ret,
    input  logic [XLEN-1:0]  cm_link_addr,
    output logic             cm_ready,
    input  logic             mispredict,
    output logic             recovering,
    output logic             ras_flush,
    output logic             ras_push,
    output logic [XLEN-1:0]  ras_push_addr,
    output logic             ras_pop
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef struct packed {
        ras_cmd_t        cmd;
        logic [XLEN-1:0] addr;
    } ras_op_t;

    ras_ctl_state_t   state_r, state_nxt_s;
    logic [IDX_W-1:0] ridx_r, ridx_nxt_s;
    logic [XLEN-1:0]  coro_addr_r;
    logic             coro_load_s;
    logic [CNT_W-1:0] cnt_s;
    logic [XLEN-1:0]  rd_data_s;
    logic             last_replay_s;
    ras_op_t          op_s;
    logic             fe_ready_s, cm_ready_s;

    ras_commit_stack #(.DEPTH(DEPTH), .XLEN(XLEN)) u_commit_stack (
        .clk          (clk),
        .rst          (rst),
        .cm_en        (cm_valid & cm_ready_s),
        .cm_is_call   (cm_is_call),
        .cm_is_ret    (cm_is_ret),
        .cm_link_addr (cm_link_addr),
        .rd_idx       (ridx_r),
        .rd_data      (rd_data_s),
        .cnt          (cnt_s)
    );

    assign last_replay_s = (CNT_W'(ridx_r) == (cnt_s - CNT_W'(1)));

    // Next-state and command decode; a mispredict always suppresses the RAS command.
    always_comb begin
        state_nxt_s = state_r;
        ridx_nxt_s  = ridx_r;
        coro_load_s = 1'b0;
        fe_ready_s  = 1'b0;
        cm_ready_s  = 1'b0;
        op_s        = '{cmd: RAS_CMD_NONE, addr: {XLEN{1'b0}}};
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cm_ready_s = 1'b1;
                    fe_ready_s = !mispredict;
                    if (mispredict) begin
                        state_nxt_s = ST_FLUSH;
                    end else if (fe_valid && fe_is_call && fe_is_ret) begin
                        op_s.cmd.pop = 1'b1;
                        fe_ready_s   = 1'b0;
                        coro_load_s  = 1'b1;
                        state_nxt_s  = ST_CORO;
                    end else if (fe_valid && fe_is_call) begin
                        op_s.cmd.push = 1'b1;
                        op_s.addr     = fe_link_addr;
                    end else if (fe_valid && fe_is_ret) begin
                        op_s.cmd.pop = 1'b1;
                    end else begin
                        op_s.cmd = RAS_CMD_NONE;
                    end
                end
                ST_CORO: begin
                    cm_ready_s = 1'b1;
                    if (mispredict) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        fe_ready_s    = 1'b1;
                        op_s.cmd.push = 1'b1;
                        op_s.addr     = coro_addr_r;
                        state_nxt_s   = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    op_s.cmd.flush = 1'b1;
                    ridx_nxt_s     = {IDX_W{1'b0}};
                    state_nxt_s    = (cnt_s != CNT_ZERO) ? ST_REPLAY : ST_IDLE;
                end
                ST_REPLAY: begin
                    if (mispredict) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        op_s.cmd.push = 1'b1;
                        op_s.addr     = rd_data_s;
                        if (last_replay_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            ridx_nxt_s = ridx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, replay index and latched coroutine link address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ridx_r      <= {IDX_W{1'b0}};
            coro_addr_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ridx_r  <= ridx_nxt_s;
            if (coro_load_s) begin
                coro_addr_r <= fe_link_addr;
            end
        end
    end

    assign fe_ready      = fe_ready_s;
    assign cm_ready      = cm_ready_s;
    assign recovering    = !rst && ((state_r == ST_FLUSH) || (state_r == ST_REPLAY));
    assign ras_flush     = op_s.cmd.flush;
    assign ras_push      = op_s.cmd.push;
    assign ras_pop       = op_s.cmd.pop;
    assign ras_push_addr = op_s.addr;

endmodule
